// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator on the system clock, advanced by a pixel enable.
// Sync, blank and coordinates are all registered from the same next-count decode.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       CLK_NX,
  input  logic       reset,
  input  logic       pixel_rate,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       von_q, von_d;
  logic       ft_q, ft_d;
  logic       h_wrap;
  logic       v_wrap;

  always_comb begin
    h_wrap = (h_q == H_MAX);
    v_wrap = (v_q == V_MAX);
    h_d    = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    end
    // Decode the position being entered so flags line up with the coordinates.
    hs_d  = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
    vs_d  = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
    von_d = (h_d < H_VIS) && (v_d < V_VIS);
    ft_d  = h_wrap && v_wrap;
  end

  always_ff @(posedge CLK_NX or posedge reset) begin
    if (reset) begin
      h_q   <= 10'd0;
      v_q   <= 10'd0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      von_q <= 1'b1;
      ft_q  <= 1'b0;
    end else if (pixel_rate) begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      ft_q  <= ft_d;
    end else begin
      ft_q  <= 1'b0;
    end
  end

  assign pixel_x    = h_q;
  assign pixel_y    = v_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign video_on   = von_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance for line timing and a shrunken
// instance so whole frames fit; both compared against a tick-count model.
module tb_vga_sync_gen;

  logic CLK_NX = 1'b0;
  logic reset;
  logic pixel_rate;

  logic       hs_b, vs_b, vo_b, ft_b;
  logic [9:0] px_b, py_b;
  logic       hs_s, vs_s, vo_s, ft_s;
  logic [9:0] px_s, py_s;

  int  checks = 0;
  int  errors = 0;
  int  n;
  bit  adv;

  always #5 CLK_NX = ~CLK_NX;

  vga_sync_gen dut (
    .CLK_NX     (CLK_NX),
    .reset      (reset),
    .pixel_rate (pixel_rate),
    .hsync      (hs_b),
    .vsync      (vs_b),
    .video_on   (vo_b),
    .pixel_x    (px_b),
    .pixel_y    (py_b),
    .frame_tick (ft_b)
  );

  vga_sync_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) dut_s (
    .CLK_NX     (CLK_NX),
    .reset      (reset),
    .pixel_rate (pixel_rate),
    .hsync      (hs_s),
    .vsync      (vs_s),
    .video_on   (vo_s),
    .pixel_x    (px_s),
    .pixel_y    (py_s),
    .frame_tick (ft_s)
  );

  wire [23:0] act_b = {ft_b, vo_b, vs_b, hs_b, py_b, px_b};
  wire [23:0] act_s = {ft_s, vo_s, vs_s, hs_s, py_s, px_s};

  // Position is just the number of counted ticks since reset, folded by the
  // line and frame lengths; flags follow from the geometric windows.
  function automatic logic [23:0] exp_vec(
    input int cnt, input bit a,
    input int hd, input int hf, input int hs, input int hb,
    input int vd, input int vf, input int vs, input int vb);
    int ht, vt, x, y;
    logic h, v, vo, ft;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    x  = cnt % ht;
    y  = (cnt / ht) % vt;
    h  = !(x >= hd + hf && x < hd + hf + hs);
    v  = !(y >= vd + vf && y < vd + vf + vs);
    vo = (x < hd) && (y < vd);
    ft = a && (cnt % (ht * vt) == 0);
    return {ft, vo, v, h, 10'(y), 10'(x)};
  endfunction

  function automatic logic [23:0] exp_b(input int cnt, input bit a);
    return exp_vec(cnt, a, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic logic [23:0] exp_s(input int cnt, input bit a);
    return exp_vec(cnt, a, 8, 2, 3, 2, 4, 1, 2, 1);
  endfunction

  task automatic step(input logic rate);
    pixel_rate = rate;
    @(posedge CLK_NX);
    adv = 1'b0;
    if (reset) n = 0;
    else if (rate) begin
      n++;
      adv = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pixel_rate = 1'b0;
    #3;
    n = 0;
    adv = 1'b0;
    checks++;
    if (act_b !== 24'h700000) begin
      errors++;
      $display("FAIL reset_async_b got=%h exp=%h", act_b, 24'h700000);
    end
    step(1'b1);
    checks++;
    if (act_b !== 24'h700000 || act_s !== 24'h700000) begin
      errors++;
      $display("FAIL reset_held got=%h/%h exp=%h", act_b, act_s, 24'h700000);
    end
    reset = 1'b0;
    step(1'b1);
    checks++;
    if (px_b !== 10'd1 || py_b !== 10'd0) begin
      errors++;
      $display("FAIL release_first got=%0d,%0d exp=1,0", px_b, py_b);
    end
  endtask

  task automatic test_line();
    int hs_low;
    hs_low = 0;
    while (n < 800) begin
      for (int k = 0; k < 3; k++) step(1'b0);
      step(1'b1);
      if (hs_b == 1'b0) hs_low++;
      checks++;
      if (act_b !== exp_b(n, adv) || act_s !== exp_s(n, adv)) begin
        errors++;
        $display("FAIL line n=%0d got=%h/%h exp=%h/%h",
                 n, act_b, act_s, exp_b(n, adv), exp_s(n, adv));
      end
      if (n == 639 || n == 640) begin
        checks++;
        if (vo_b !== (n == 639)) begin
          errors++;
          $display("FAIL vis_edge n=%0d got=%b exp=%b", n, vo_b, n == 639);
        end
      end
    end
    checks++;
    if (hs_low != 96) begin
      errors++;
      $display("FAIL hsync_width got=%0d exp=96", hs_low);
    end
    checks++;
    if (px_b !== 10'd0 || py_b !== 10'd1 || vo_b !== 1'b1) begin
      errors++;
      $display("FAIL line_wrap got=%0d,%0d,%b exp=0,1,1", px_b, py_b, vo_b);
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int k = 0; k < 300; k++) step(1'b1);
    for (int k = 0; k < 1000; k++) begin
      step(1'b0);
      checks++;
      if (act_b !== exp_b(n, adv) || act_s !== exp_s(n, adv)) begin
        errors++;
        $display("FAIL hold k=%0d got=%h/%h exp=%h/%h",
                 k, act_b, act_s, exp_b(n, adv), exp_s(n, adv));
      end
    end
    for (int k = 0; k < 500; k++) begin
      step(1'b1);
      checks++;
      if (act_b !== exp_b(n, adv) || act_s !== exp_s(n, adv)) begin
        errors++;
        $display("FAIL run_high n=%0d got=%h/%h exp=%h/%h",
                 n, act_b, act_s, exp_b(n, adv), exp_s(n, adv));
      end
    end
    checks++;
    if (px_b !== 10'd0 || py_b !== 10'd1) begin
      errors++;
      $display("FAIL hold_wrap got=%0d,%0d exp=0,1", px_b, py_b);
    end
  endtask

  task automatic test_frames_small();
    int ticks, vs_low, first;
    ticks = 0;
    vs_low = 0;
    first = -1;
    do_reset();
    for (int k = 0; k < 1200; k++) begin
      step(1'b1);
      if (vs_s == 1'b0) vs_low++;
      if (ft_s) begin
        ticks++;
        if (first < 0) first = n;
      end
      checks++;
      if (act_s !== exp_s(n, adv)) begin
        errors++;
        $display("FAIL frame_s n=%0d got=%h exp=%h", n, act_s, exp_s(n, adv));
      end
    end
    checks++;
    if (ticks != 10 || first != 120) begin
      errors++;
      $display("FAIL frame_ticks got=%0d@%0d exp=10@120", ticks, first);
    end
    checks++;
    if (vs_low != 300) begin
      errors++;
      $display("FAIL vsync_width got=%0d exp=300", vs_low);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 700; k++) step(1'b1);
    checks++;
    if (px_b !== 10'd700 || hs_b !== 1'b0 || hs_s !== 1'b0 || vs_s !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset got=%0d,%b,%b,%b exp=700,0,0,0",
               px_b, hs_b, hs_s, vs_s);
    end
    #2;
    reset = 1'b1;
    #1;
    n = 0;
    adv = 1'b0;
    checks++;
    if (act_b !== 24'h700000 || act_s !== 24'h700000) begin
      errors++;
      $display("FAIL midcycle_reset got=%h/%h exp=%h", act_b, act_s, 24'h700000);
    end
    step(1'b1);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1);
      checks++;
      if (act_b !== exp_b(n, adv) || act_s !== exp_s(n, adv)) begin
        errors++;
        $display("FAIL resume n=%0d got=%h/%h exp=%h/%h",
                 n, act_b, act_s, exp_b(n, adv), exp_s(n, adv));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 99) < 40);
      checks++;
      if (act_b !== exp_b(n, adv) || act_s !== exp_s(n, adv)) begin
        errors++;
        $display("FAIL random n=%0d got=%h/%h exp=%h/%h",
                 n, act_b, act_s, exp_b(n, adv), exp_s(n, adv));
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    pixel_rate = 1'b0;
    n = 0;
    adv = 1'b0;
    #2;
    test_reset();
    test_line();
    test_hold();
    test_frames_small();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
